// File: rtl/if_stage_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, redirect
// from execute and the decode-side handshake.
// The fetch_misalign signal exists only when FETCH_MISALIGN_CHECK_EN is defined.
interface if_stage_if;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] inst;
    logic [63:0] inst_addr;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        fetch_misalign;
`endif

    // fetch stage side
    modport master (
`ifdef FETCH_MISALIGN_CHECK_EN
        output fetch_misalign,
`endif
        output imem_req, imem_addr, if_valid, inst, inst_addr,
        input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, id_ready
    );

    // memory / execute / decode side
    modport slave (
`ifdef FETCH_MISALIGN_CHECK_EN
        input  fetch_misalign,
`endif
        input  imem_req, imem_addr, if_valid, inst, inst_addr,
        output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, id_ready
    );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: REQ/WAIT/DROP fetch FSM, one outstanding request,
// 2-entry {addr, inst} buffer towards decode, redirect flushes everything.
// Optional macro FETCH_MISALIGN_CHECK_EN: a misaligned redirect raises
// fetch_misalign and halts fetching until the next aligned redirect;
// without it the redirect target is silently word-aligned.
module if_stage #(
    parameter logic [63:0] RESET_PC  = 64'h0000_0000_8000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input logic        clk,
    input logic        rst_n,
    if_stage_if.master bus
);
    localparam logic [1:0]  S_REQ    = 2'd0;
    localparam logic [1:0]  S_WAIT   = 2'd1;
    localparam logic [1:0]  S_DROP   = 2'd2;
    localparam logic [1:0]  FULL_CNT = 2'(BUF_DEPTH);
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [63:0] r_pc;
    logic [63:0] r_req_addr;
    logic [63:0] r_fifo_addr [2];
    logic [31:0] r_fifo_inst [2];
    logic        r_head;
    logic [1:0]  r_cnt;
    logic        r_started;
    logic        w_halt;
    logic        w_req;
    logic        w_grant;
    logic        w_push;
    logic        w_pop;
    logic        w_tail;
    logic        w_valid;
    logic [63:0] w_redir_pc;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic r_misalign;

    // misaligned redirect halts fetching until an aligned redirect arrives
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_misalign <= 1'b0;
        else if (bus.redirect_valid)
            r_misalign <= (bus.redirect_pc[1:0] != 2'b00);
    end

    assign w_halt             = r_misalign;
    assign w_redir_pc         = bus.redirect_pc;
    assign bus.fetch_misalign = r_misalign;
`else
    assign w_halt     = 1'b0;
    assign w_redir_pc = bus.redirect_pc & ~64'h3;
`endif

    // r_started keeps imem_req low until the first edge after reset release
    assign w_req   = r_started && (r_state == S_REQ) && (r_cnt < FULL_CNT) && !w_halt;
    assign w_grant = w_req && bus.imem_gnt;
    // redirect overrides push and pop: the buffer is simply emptied
    assign w_push  = (r_state == S_WAIT) && bus.imem_rvalid && !bus.redirect_valid;
    assign w_valid = (r_cnt != 2'd0);
    assign w_pop   = w_valid && bus.id_ready && !bus.redirect_valid;
    assign w_tail  = r_head ^ r_cnt[0];

    // fetch FSM: a redirect with a request in flight must drop its response
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_REQ: begin
                if (w_grant)
                    w_state_nxt = bus.redirect_valid ? S_DROP : S_WAIT;
            end
            S_WAIT: begin
                if (bus.imem_rvalid)
                    w_state_nxt = S_REQ;
                else if (bus.redirect_valid)
                    w_state_nxt = S_DROP;
            end
            S_DROP: begin
                if (bus.imem_rvalid)
                    w_state_nxt = S_REQ;
            end
            default: w_state_nxt = S_REQ;
        endcase
    end

    // state, pc and the address of the request in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_REQ;
            r_pc       <= RESET_PC;
            r_req_addr <= '0;
            r_started  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_started <= 1'b1;
            if (w_grant)
                r_req_addr <= r_pc;
            if (bus.redirect_valid)
                r_pc <= w_redir_pc;
            else if (w_grant)
                r_pc <= r_pc + 64'd4;
        end
    end

    // 2-entry instruction buffer, head pointer plus occupancy count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= 1'b0;
            r_cnt  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_fifo_addr[i] <= '0;
                r_fifo_inst[i] <= '0;
            end
        end else if (bus.redirect_valid) begin
            r_cnt <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo_addr[w_tail] <= r_req_addr;
                r_fifo_inst[w_tail] <= bus.imem_rdata;
            end
            if (w_pop)
                r_head <= ~r_head;
            r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign bus.imem_req  = w_req;
    assign bus.imem_addr = r_pc;
    assign bus.if_valid  = w_valid;
    assign bus.inst      = w_valid ? r_fifo_inst[r_head] : NOP;
    assign bus.inst_addr = w_valid ? r_fifo_addr[r_head] : 64'h0;
endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed table, multi-cycle corner
// sequences and a randomized run against a queue-based reference model.
`timescale 1ns/1ps
module tb_if_stage;
    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    if_stage_if bus();

    if_stage #(.RESET_PC(RESET_PC), .BUF_DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // memory model: pending responses with their due edge
    typedef struct { logic [63:0] addr; int due; } pend_t;
    pend_t pq[$];
    int    cyc = 0;
    int    lat = 1;
    int    gnt_pct = 100;

    // stimulus for the next cycle
    logic        t_ready = 1'b1;
    logic        t_redir = 1'b0;
    logic [63:0] t_rpc   = '0;

    // sampled memory response for the current cycle
    logic        s_rvalid;
    logic [63:0] s_raddr;

    // reference model: buffer contents as a queue, plain pc arithmetic
    typedef struct { logic [63:0] addr; logic [31:0] inst; } ent_t;
    ent_t        m_buf[$];
    logic [63:0] m_pc, m_lat;
    bit          m_out, m_stale, m_halt, m_started, m_exp_req;

    typedef struct {
        logic        exp_req;
        logic [63:0] exp_iaddr;
        logic        exp_valid;
        logic [63:0] exp_inst_addr;
    } vec_t;
    vec_t tbl[8];

    function automatic logic [31:0] memword(input logic [63:0] a);
        logic [31:0] lo;
        lo = a[31:0];
        return (lo * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_buf.delete();
        m_pc      = RESET_PC;
        m_lat     = '0;
        m_out     = 0;
        m_stale   = 0;
        m_halt    = 0;
        m_started = 0;
    endtask

    // drive inputs on the falling edge, then compare outputs with the model
    task automatic drive_and_sample();
        pend_t p;
        ent_t  h;
        @(negedge clk);
        bus.id_ready       = t_ready;
        bus.redirect_valid = t_redir;
        bus.redirect_pc    = t_rpc;
        bus.imem_gnt       = ($urandom_range(0, 99) < gnt_pct);
        s_rvalid = 1'b0;
        s_raddr  = '0;
        if (pq.size() > 0 && pq[0].due <= cyc + 1) begin
            s_rvalid = 1'b1;
            s_raddr  = pq[0].addr;
            void'(pq.pop_front());
        end
        bus.imem_rvalid = s_rvalid;
        bus.imem_rdata  = s_rvalid ? memword(s_raddr) : $urandom;
        #1;
        m_exp_req = m_started && !m_out && (m_buf.size() < 2) && !m_halt;
        chk("imem_req", bus.imem_req, m_exp_req);
        if (m_exp_req)
            chk("imem_addr", bus.imem_addr, m_pc);
        chk("if_valid", bus.if_valid, m_buf.size() != 0);
        if (m_buf.size() != 0) begin
            h = m_buf[0];
            chk("inst_addr", bus.inst_addr, h.addr);
            chk("inst", bus.inst, h.inst);
        end else begin
            chk("inst_addr_empty", bus.inst_addr, 64'h0);
            chk("inst_empty", bus.inst, NOP);
        end
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("fetch_misalign", bus.fetch_misalign, m_halt);
`endif
        if (bus.imem_req && bus.imem_gnt) begin
            p.addr = bus.imem_addr;
            p.due  = cyc + 1 + lat;
            pq.push_back(p);
        end
    endtask

    // advance the model by one edge and let the clock rise
    task automatic finish_cycle();
        ent_t e;
        bit   g;
        g = m_exp_req && bus.imem_gnt;
        if (t_redir) begin
            m_buf.delete();
            if (g) begin
                m_out = 1; m_stale = 1;
            end else if (s_rvalid) begin
                m_out = 0;
            end else if (m_out) begin
                m_stale = 1;
            end
`ifdef FETCH_MISALIGN_CHECK_EN
            m_pc   = t_rpc;
            m_halt = (t_rpc[1:0] != 2'b00);
`else
            m_pc   = {t_rpc[63:2], 2'b00};
`endif
        end else begin
            if (m_buf.size() > 0 && t_ready)
                void'(m_buf.pop_front());
            if (s_rvalid) begin
                if (!m_stale) begin
                    e.addr = m_lat;
                    e.inst = bus.imem_rdata;
                    m_buf.push_back(e);
                end
                m_out = 0;
            end
            if (g) begin
                m_out = 1; m_stale = 0; m_lat = m_pc; m_pc = m_pc + 64'd4;
            end
        end
        m_started = 1;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic step();
        drive_and_sample();
        finish_cycle();
    endtask

    // reset with outputs checked while rst_n is low; release just after a rising edge
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.imem_rvalid    = 1'b0;
        bus.imem_gnt       = 1'b0;
        bus.redirect_valid = 1'b0;
        t_redir = 1'b0;
        pq.delete();
        #1;
        chk("rst_imem_req", bus.imem_req, 1'b0);
        chk("rst_if_valid", bus.if_valid, 1'b0);
        chk("rst_inst", bus.inst, NOP);
        chk("rst_inst_addr", bus.inst_addr, 64'h0);
        chk("rst_imem_addr", bus.imem_addr, RESET_PC);
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("rst_misalign", bus.fetch_misalign, 1'b0);
`endif
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic wait_valid(input string name, input logic [63:0] exp_addr);
        int n;
        n = 0;
        while (!bus.if_valid && n < 30) begin
            step();
            n++;
        end
        chk(name, bus.inst_addr, exp_addr);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] a;
        bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
        bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.id_ready = 1'b0;
        model_reset();

        // in-order fetch with 1-cycle memory and decode always ready
        tbl[0] = '{1'b0, 64'h0,          1'b0, 64'h0};
        tbl[1] = '{1'b1, 64'h8000_0000, 1'b0, 64'h0};
        tbl[2] = '{1'b0, 64'h0,          1'b0, 64'h0};
        tbl[3] = '{1'b1, 64'h8000_0004, 1'b1, 64'h8000_0000};
        tbl[4] = '{1'b0, 64'h0,          1'b0, 64'h0};
        tbl[5] = '{1'b1, 64'h8000_0008, 1'b1, 64'h8000_0004};
        tbl[6] = '{1'b0, 64'h0,          1'b0, 64'h0};
        tbl[7] = '{1'b1, 64'h8000_000C, 1'b1, 64'h8000_0008};

        lat = 1; gnt_pct = 100; t_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive_and_sample();
            chk("tbl_req", bus.imem_req, tbl[i].exp_req);
            if (tbl[i].exp_req) chk("tbl_iaddr", bus.imem_addr, tbl[i].exp_iaddr);
            chk("tbl_valid", bus.if_valid, tbl[i].exp_valid);
            chk("tbl_inst_addr", bus.inst_addr, tbl[i].exp_inst_addr);
            if (tbl[i].exp_valid) chk("tbl_inst", bus.inst, memword(tbl[i].exp_inst_addr));
            finish_cycle();
        end

        // decode stalls: buffer fills to two, requests stop, then drains in order
        t_ready = 1'b0;
        repeat (10) step();
        chk("full_req", bus.imem_req, 1'b0);
        chk("full_valid", bus.if_valid, 1'b1);
        chk("full_head", bus.inst_addr, 64'h8000_000C);
        t_ready = 1'b1;
        step();
        chk("drain_second", bus.inst_addr, 64'h8000_0010);
        chk("drain_req", bus.imem_req, 1'b1);
        chk("drain_iaddr", bus.imem_addr, 64'h8000_0014);

        // redirect in WAIT, response two cycles later is dropped
        lat = 3;
        do_reset();
        step(); step();
        t_redir = 1'b1; t_rpc = 64'h8000_0100;
        step();
        t_redir = 1'b0;
        chk("drop_valid", bus.if_valid, 1'b0);
        chk("drop_req", bus.imem_req, 1'b0);
        step(); step();
        chk("drop_resume_req", bus.imem_req, 1'b1);
        chk("drop_resume_addr", bus.imem_addr, 64'h8000_0100);
        wait_valid("drop_first_valid", 64'h8000_0100);

        // redirect coinciding with rvalid while decode is ready
        lat = 1; t_ready = 1'b0;
        do_reset();
        repeat (4) step();
        chk("pre_redir_valid", bus.if_valid, 1'b1);
        chk("pre_redir_head", bus.inst_addr, 64'h8000_0000);
        t_redir = 1'b1; t_rpc = 64'h8000_0300; t_ready = 1'b1;
        step();
        t_redir = 1'b0;
        chk("rv_redir_valid", bus.if_valid, 1'b0);
        chk("rv_redir_req", bus.imem_req, 1'b1);
        chk("rv_redir_addr", bus.imem_addr, 64'h8000_0300);
        wait_valid("rv_redir_first", 64'h8000_0300);

        // misaligned redirect target
        lat = 1; t_ready = 1'b1;
        do_reset();
        step(); step();
        t_redir = 1'b1; t_rpc = 64'h8000_0102;
        step();
        t_redir = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("mis_flag", bus.fetch_misalign, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("mis_halt_req", bus.imem_req, 1'b0);
            step();
        end
        t_redir = 1'b1; t_rpc = 64'h8000_0200;
        step();
        t_redir = 1'b0;
        chk("mis_clear", bus.fetch_misalign, 1'b0);
        chk("mis_resume_req", bus.imem_req, 1'b1);
        chk("mis_resume_addr", bus.imem_addr, 64'h8000_0200);
`else
        chk("align_req", bus.imem_req, 1'b1);
        chk("align_addr", bus.imem_addr, 64'h8000_0100);
`endif

        // reset in the middle of WAIT
        lat = 5;
        do_reset();
        step(); step(); step();
        do_reset();
        step();
        chk("rst2_req", bus.imem_req, 1'b1);
        chk("rst2_addr", bus.imem_addr, RESET_PC);
        chk("rst2_valid", bus.if_valid, 1'b0);

        // randomized traffic against the reference model
        gnt_pct = 70;
        for (int r = 0; r < 3; r++) begin
            do_reset();
            for (int i = 0; i < 1000; i++) begin
                lat     = $urandom_range(1, 4);
                t_ready = ($urandom_range(0, 99) < 70);
                t_redir = ($urandom_range(0, 99) < 5);
                a = 64'h8000_0000 + 64'($urandom_range(0, 1023)) * 64'd4;
                if ($urandom_range(0, 3) == 0)
                    a[1:0] = 2'($urandom_range(1, 3));
                t_rpc = a;
                step();
            end
            t_redir = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 64'h0000_0000_8000_0000, first fetch address after reset.
REQ-002 Parameter BUF_DEPTH, default 2, instruction buffer entries; only the value 2 is supported.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 imem_req  out  1  fetch request to instruction memory.
REQ-006 imem_addr  out  64  fetch address; equals pc whenever imem_req=1.
REQ-007 imem_gnt  in  1  memory accepts the request in the same cycle as imem_req.
REQ-008 imem_rvalid  in  1  read data valid, one per granted request, at least 1 cycle after grant, in order.
REQ-009 imem_rdata  in  32  instruction word.
REQ-010 redirect_valid  in  1  branch/jump redirect from execute.
REQ-011 redirect_pc  in  64  redirect target.
REQ-012 id_ready  in  1  decode stage accepts the current instruction.
REQ-013 if_valid  out  1  inst and inst_addr are valid.
REQ-014 inst  out  32  instruction to decode.
REQ-015 inst_addr  out  64  address of inst.
REQ-016 fetch_misalign  out  1  misaligned redirect flag; present only with FETCH_MISALIGN_CHECK_EN.

Function
REQ-017 The fetch FSM SHALL have states REQ, WAIT and DROP, with a 64-bit pc register and a 2-entry FIFO of {addr, inst}.
REQ-018 In REQ, imem_req SHALL be 1 iff (fifo count) < 2 and the block is not halted; imem_addr=pc.
REQ-019 On imem_req & imem_gnt, the block SHALL latch the request address, set pc<=pc+4 (64-bit wrap) and go to WAIT.
REQ-020 In WAIT, imem_req SHALL be 0; on imem_rvalid it SHALL push {latched addr, imem_rdata} and go to REQ.
REQ-021 At most one request SHALL be outstanding; a push SHALL never occur with the FIFO full.
REQ-022 if_valid SHALL equal (count != 0); inst/inst_addr SHALL show the FIFO head; when empty, inst=32'h0000_0013 (NOP) and inst_addr=0.
REQ-023 The head SHALL pop on if_valid & id_ready; simultaneous push and pop SHALL leave the count unchanged.
REQ-024 On redirect_valid the block SHALL, at the next edge, empty the FIFO and set pc<=redirect_pc, overriding any push, pop or pc+4 update in that cycle.
REQ-025 Redirect in WAIT without rvalid, or in REQ coinciding with a grant, SHALL go to DROP; redirect in WAIT with rvalid SHALL discard the data and go to REQ.
REQ-026 In DROP, imem_req SHALL be 0; the next imem_rvalid SHALL be discarded and the FSM SHALL go to REQ.
REQ-027 A redirect in DROP SHALL update pc and stay in DROP.
REQ-028 if_valid SHALL be 0 in the cycle after any redirect.

Reset
REQ-029 While rst_n=0: pc=RESET_PC, state=REQ, FIFO empty, imem_req=0, if_valid=0, inst=32'h13, inst_addr=0, fetch_misalign=0.
REQ-030 Reset asserted mid-transaction SHALL abandon the outstanding request; memory is also reset, so no stale rvalid is expected.
REQ-031 imem_req SHALL be asserted no earlier than the first rising edge after rst_n deasserts.

Configuration
REQ-032 With FETCH_MISALIGN_CHECK_EN defined, a redirect with redirect_pc[1:0]!=0 SHALL set fetch_misalign=1 and halt requests; the next aligned redirect SHALL clear fetch_misalign and resume fetching.
REQ-033 Without FETCH_MISALIGN_CHECK_EN, the fetch_misalign port SHALL be absent and pc SHALL load {redirect_pc[63:2], 2'b00}.

Verification
REQ-034 Reset release, gnt=1, rvalid 1 cycle after each grant, id_ready=1 -> inst_addr sequence 0x8000_0000, 0x8000_0004, 0x8000_0008 with matching inst.
REQ-035 id_ready=0 for 10 cycles -> exactly 2 entries buffered, imem_req=0 while full; on release, both entries pop in order with no loss.
REQ-036 Redirect to 0x8000_0100 while in WAIT, rvalid arrives 2 cycles later -> that word is dropped; next if_valid shows inst_addr=0x8000_0100.
REQ-037 Redirect in the same cycle as imem_rvalid and id_ready=1 -> FIFO empties, no pop is observed, the rvalid data is discarded, and fetch restarts at the target.
REQ-038 With the macro defined, redirect to 0x8000_0102 -> fetch_misalign=1, imem_req=0; a later redirect to 0x8000_0200 -> flag clears and fetch resumes at 0x8000_0200. Without the macro, the same first redirect -> fetch at 0x8000_0100.
REQ-039 rst_n low mid-WAIT, then released -> all outputs at reset values; first fetch at RESET_PC.
